// File: rtl/mc_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath mux select, register write strobe and the ALU code.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   opcode_i, funct_i  instruction register fields
//   zero_i             ALU zero flag, used in BRANCH only
//   iord_o .. pc_en_o  datapath controls (Moore, registered; pc_en_o gates zero_i)
//   state_o            current state encoding
module mc_control_fsm (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  output logic       iord_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_control_o,
  output logic [1:0] pc_src_o,
  output logic       pc_en_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  state_e     state_q, state_d;
  // Cleared by reset: the first edge after release only opens the first FETCH.
  logic       run_q;
  logic       iord_q, iord_d;
  logic       mem_write_q, mem_write_d;
  logic       ir_write_q, ir_write_d;
  logic       reg_dst_q, reg_dst_d;
  logic       mem_to_reg_q, mem_to_reg_d;
  logic       reg_write_q, reg_write_d;
  logic       alu_src_a_q, alu_src_a_d;
  logic [1:0] alu_src_b_q, alu_src_b_d;
  logic [2:0] alu_control_q, alu_control_d;
  logic [1:0] pc_src_q, pc_src_d;
  logic       pc_write_q, pc_write_d;
  logic       branch_q, branch_d;
  logic [2:0] funct_alu;

  always_comb begin
    case (funct_i)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_alu = 3'b010;
    endcase
  end

  always_comb begin
    state_d = StFetch;
    if (run_q) begin
      case (state_q)
        StFetch:  state_d = StDecode;
        StDecode: begin
          case (opcode_i)
            OpLw, OpSw: state_d = StMemAdr;
            OpRtype:    state_d = StExec;
            OpBeq:      state_d = StBranch;
            OpAddi:     state_d = StAddiEx;
            OpJ:        state_d = StJump;
            default:    state_d = StFetch;
          endcase
        end
        StMemAdr: state_d = (opcode_i == OpSw) ? StMemWr : StMemRd;
        StMemRd:  state_d = StMemWb;
        StExec:   state_d = StAluWb;
        StAddiEx: state_d = StAddiWb;
        default:  state_d = StFetch;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copies are
  // exactly the Moore decode of state_q.
  always_comb begin
    iord_d        = 1'b0;
    mem_write_d   = 1'b0;
    ir_write_d    = 1'b0;
    reg_dst_d     = 1'b0;
    mem_to_reg_d  = 1'b0;
    reg_write_d   = 1'b0;
    alu_src_a_d   = 1'b0;
    alu_src_b_d   = 2'b00;
    alu_control_d = 3'b010;
    pc_src_d      = 2'b00;
    pc_write_d    = 1'b0;
    branch_d      = 1'b0;
    case (state_d)
      StFetch: begin
        alu_src_b_d = 2'b01;
        ir_write_d  = 1'b1;
        pc_write_d  = 1'b1;
      end
      StDecode: alu_src_b_d = 2'b11;
      StMemAdr, StAddiEx: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      StMemRd: iord_d = 1'b1;
      StMemWb: begin
        mem_to_reg_d = 1'b1;
        reg_write_d  = 1'b1;
      end
      StMemWr: begin
        iord_d      = 1'b1;
        mem_write_d = 1'b1;
      end
      StExec: begin
        alu_src_a_d   = 1'b1;
        alu_control_d = funct_alu;
      end
      StAluWb: begin
        reg_dst_d   = 1'b1;
        reg_write_d = 1'b1;
      end
      StBranch: begin
        alu_src_a_d   = 1'b1;
        alu_control_d = 3'b110;
        pc_src_d      = 2'b01;
        branch_d      = 1'b1;
      end
      StAddiWb: reg_write_d = 1'b1;
      StJump: begin
        pc_src_d   = 2'b10;
        pc_write_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset loads the FETCH select decode with every strobe held low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StFetch;
      run_q         <= 1'b0;
      iord_q        <= 1'b0;
      mem_write_q   <= 1'b0;
      ir_write_q    <= 1'b0;
      reg_dst_q     <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      reg_write_q   <= 1'b0;
      alu_src_a_q   <= 1'b0;
      alu_src_b_q   <= 2'b01;
      alu_control_q <= 3'b010;
      pc_src_q      <= 2'b00;
      pc_write_q    <= 1'b0;
      branch_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= 1'b1;
      iord_q        <= iord_d;
      mem_write_q   <= mem_write_d;
      ir_write_q    <= ir_write_d;
      reg_dst_q     <= reg_dst_d;
      mem_to_reg_q  <= mem_to_reg_d;
      reg_write_q   <= reg_write_d;
      alu_src_a_q   <= alu_src_a_d;
      alu_src_b_q   <= alu_src_b_d;
      alu_control_q <= alu_control_d;
      pc_src_q      <= pc_src_d;
      pc_write_q    <= pc_write_d;
      branch_q      <= branch_d;
    end
  end

  assign iord_o        = iord_q;
  assign mem_write_o   = mem_write_q;
  assign ir_write_o    = ir_write_q;
  assign reg_dst_o     = reg_dst_q;
  assign mem_to_reg_o  = mem_to_reg_q;
  assign reg_write_o   = reg_write_q;
  assign alu_src_a_o   = alu_src_a_q;
  assign alu_src_b_o   = alu_src_b_q;
  assign alu_control_o = alu_control_q;
  assign pc_src_o      = pc_src_q;
  // Only input-dependent output: a taken branch loads the PC.
  assign pc_en_o       = pc_write_q | (branch_q & zero_i);
  assign state_o       = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  mc_control_fsm dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .opcode_i     (opcode),
    .funct_i      (funct),
    .zero_i       (zero),
    .iord_o       (iord),
    .mem_write_o  (mem_write),
    .ir_write_o   (ir_write),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .reg_write_o  (reg_write),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_control_o(alu_control),
    .pc_src_o     (pc_src),
    .pc_en_o      (pc_en),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_write, branch;
  } ctl_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected control word per state code, straight from the output table.
  function automatic ctl_t exp_out(input int st, input logic [5:0] fn);
    ctl_t c;
    c = '0;
    c.alu_control = 3'b010;
    case (st)
      0:  begin c.alu_src_b = 2'b01; c.ir_write = 1; c.pc_write = 1; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  c.iord = 1;
      4:  begin c.mem_to_reg = 1; c.reg_write = 1; end
      5:  begin c.iord = 1; c.mem_write = 1; end
      6:  begin c.alu_src_a = 1; c.alu_control = alu_of(fn); end
      7:  begin c.reg_dst = 1; c.reg_write = 1; end
      8:  begin c.alu_src_a = 1; c.alu_control = 3'b110; c.pc_src = 2'b01; c.branch = 1; end
      9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      10: c.reg_write = 1;
      11: begin c.pc_src = 2'b10; c.pc_write = 1; end
      default: ;
    endcase
    return c;
  endfunction

  // Whole-instruction state trace, FETCH inclusive.
  function automatic void seq_of(input logic [5:0] op, output int q[$]);
    case (op)
      6'b100011: q = {0, 1, 2, 3, 4};
      6'b101011: q = {0, 1, 2, 5};
      6'b000000: q = {0, 1, 6, 7};
      6'b000100: q = {0, 1, 8};
      6'b001000: q = {0, 1, 9, 10};
      6'b000010: q = {0, 1, 11};
      default:   q = {0, 1};
    endcase
  endfunction

  // Precondition: just after the edge that opened a FETCH cycle.
  // zmode: 0/1 hold zero at that value, 2 randomise it every cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode);
    int   s[$];
    ctl_t c;
    logic ep;
    int   n_rw, n_mw, n_ir, n_pce, n_epce;
    n_rw = 0; n_mw = 0; n_ir = 0; n_pce = 0; n_epce = 0;
    opcode = op;
    funct  = fn;
    seq_of(op, s);
    foreach (s[k]) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      c  = exp_out(s[k], fn);
      ep = c.pc_write | (c.branch & zero);
      chk("state", 32'(state), 32'(s[k]));
      chk("ctl", 32'({iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                      alu_src_b, alu_control, pc_src}), 32'(c[15:2]));
      chk("pc_en", 32'(pc_en), 32'(ep));
      chk("one_strobe", 32'((32'(reg_write) + 32'(mem_write) + 32'(ir_write)) <= 1), 32'd1);
      n_rw   += int'(reg_write);
      n_mw   += int'(mem_write);
      n_ir   += int'(ir_write);
      n_pce  += int'(pc_en);
      n_epce += int'(ep);
      @(posedge clk);
      #1;
    end
    chk("end_state", 32'(state), 32'd0);
    chk("rw_cnt", 32'(n_rw), (op == 6'b100011 || op == 6'b000000 || op == 6'b001000) ? 1 : 0);
    chk("mw_cnt", 32'(n_mw), (op == 6'b101011) ? 1 : 0);
    chk("ir_cnt", 32'(n_ir), 32'd1);
    chk("pce_cnt", 32'(n_pce), 32'(n_epce));
  endtask

  logic [5:0] functs[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [5:0] ops[6]    = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

  initial begin
    rst    = 1'b1;
    opcode = 6'b0;
    funct  = 6'b0;
    zero   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ir", 32'(ir_write), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_state", 32'(state), 32'd0);
    chk("first_ir", 32'(ir_write), 32'd1);
    chk("first_pc_en", 32'(pc_en), 32'd1);

    run_instr(6'b100011, 6'b000000, 0);  // lw
    run_instr(6'b000000, 6'b100010, 0);  // sub
    run_instr(6'b000100, 6'b000000, 1);  // beq taken
    run_instr(6'b000100, 6'b000000, 0);  // beq not taken
    run_instr(6'b000010, 6'b000000, 1);  // j, zero high must not matter
    run_instr(6'b001000, 6'b000000, 1);  // addi
    run_instr(6'b111111, 6'b000000, 1);  // unsupported
    run_instr(6'b000000, 6'b000111, 0);  // unknown funct
    run_instr(6'b101011, 6'b000000, 2);  // sw

    // Asynchronous reset in the middle of MEMRD.
    opcode = 6'b100011;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_state", 32'(state), 32'd3);
    #2;
    rst  = 1'b1;
    zero = 1'b1;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_strobes", 32'({ir_write, pc_en, reg_write, mem_write}), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("hold_state", 32'(state), 32'd0);
      chk("hold_strobes", 32'({ir_write, pc_en, reg_write, mem_write}), 32'd0);
      chk("hold_sel", 32'({alu_src_b, alu_control, iord, alu_src_a, pc_src}), 32'h0a0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_state", 32'(state), 32'd0);
    chk("rel_ir", 32'(ir_write), 32'd1);
    chk("rel_pc_en", 32'(pc_en), 32'd1);

    for (int i = 0; i < 200; i++) begin
      logic [5:0] op, fn;
      int r;
      r  = int'($urandom_range(0, 7));
      op = (r < 6) ? ops[r] : 6'($urandom);
      r  = int'($urandom_range(0, 6));
      fn = (r < 5) ? functs[r] : 6'($urandom);
      run_instr(op, fn, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
